// File: rtl/aes_key_schedule_seq.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_schedule_seq (with helper aes_sbox)
// Purpose  : Iterative AES key schedule for AES-128/192/256, mode chosen per
//            request. Produces one 32-bit schedule word per clock into an
//            internal word array. Round keys are read back through a
//            combinational port indexed by round number.
// Ports    : clk, reset (async, active-high)
//            start/key_len/key      - expansion request (accepted when ready)
//            ready/busy/done        - handshake and status
//            keys_valid             - schedule complete and stable
//            nr                     - round count of the latched mode
//            rk_index -> rk_data    - 128-bit round key read port
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// aes_sbox : single AES S-box byte, computed as the GF(2^8) multiplicative
// inverse (x^254) followed by the AES affine transform.
// ----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_sq;
    logic [7:0] w_inv;

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires.
    always_comb begin
        w_sq  = i_byte;
        w_inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            w_sq  = gf_mul(w_sq, w_sq);
            w_inv = gf_mul(w_inv, w_sq);
        end
        o_byte = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ 8'h63;
    end

endmodule

// ----------------------------------------------------------------------------
// aes_key_schedule_seq : top level
// ----------------------------------------------------------------------------
module aes_key_schedule_seq #(
    parameter int MAX_NK    = 8,
    parameter int MAX_WORDS = 60,
    parameter int RK_IDX_W  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             key_len,
    input  logic [0:MAX_NK*32-1]   key,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic                   keys_valid,
    output logic [3:0]             nr,
    input  logic [RK_IDX_W-1:0]    rk_index,
    output logic [0:127]           rk_data
);

    localparam int WIDX_W = $clog2(MAX_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_EXPAND = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [31:0]           r_words [MAX_WORDS];
    logic [0:MAX_NK*32-1]  r_key;
    logic [1:0]            r_key_len;
    logic [WIDX_W-1:0]     r_i;
    logic [2:0]            r_mod;      // i mod Nk, wrapping counter
    logic [7:0]            r_rcon;
    logic [3:0]            r_nr;
    logic                  r_done;
    logic                  r_keys_valid;

    logic                  w_accept;
    logic [3:0]            w_nk;
    logic [2:0]            w_nk_m1;
    logic [WIDX_W-1:0]     w_last;
    logic [3:0]            w_nr_req;
    logic                  w_last_word;
    logic [31:0]           w_prev;
    logic [31:0]           w_back;
    logic [31:0]           w_sub_in;
    logic [31:0]           w_sub_out;
    logic [31:0]           w_temp;
    logic [WIDX_W-1:0]     w_base;

    // ------------------------------------------------------------------
    // Mode decode from the latched key length
    // ------------------------------------------------------------------
    always_comb begin
        case (r_key_len)
            2'd0: begin
                w_nk    = 4'd4;
                w_nk_m1 = 3'd3;
                w_last  = WIDX_W'(43);
            end
            2'd1: begin
                w_nk    = 4'd6;
                w_nk_m1 = 3'd5;
                w_last  = WIDX_W'(51);
            end
            default: begin
                w_nk    = 4'd8;
                w_nk_m1 = 3'd7;
                w_last  = WIDX_W'(59);
            end
        endcase
    end

    // Round count of the incoming request, latched on acceptance
    always_comb begin
        case (key_len)
            2'd0:    w_nr_req = 4'd10;
            2'd1:    w_nr_req = 4'd12;
            default: w_nr_req = 4'd14;
        endcase
    end

    assign w_last_word = (r_i == w_last);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        ready        = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                ready = 1'b1;
                // key_len=3 is an illegal mode: the request is dropped
                if (start && (key_len != 2'd3)) begin
                    w_accept     = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                busy         = 1'b1;
                w_state_next = S_EXPAND;
            end
            S_EXPAND: begin
                busy = 1'b1;
                if (w_last_word) w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared SubWord: RotWord is applied only on the i mod Nk == 0 step
    // ------------------------------------------------------------------
    assign w_prev   = r_words[r_i - WIDX_W'(1)];
    assign w_back   = r_words[r_i - WIDX_W'(w_nk)];
    assign w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    generate
        for (genvar b = 0; b < 4; b++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_sub_in[8*b +: 8]),
                .o_byte (w_sub_out[8*b +: 8])
            );
        end
    endgenerate

    always_comb begin
        w_temp = w_prev;
        if (r_mod == 3'd0) begin
            w_temp = w_sub_out ^ {r_rcon, 24'h000000};
        end else if ((w_nk == 4'd8) && (r_mod == 3'd4)) begin
            w_temp = w_sub_out;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: key latch, word array, counters, status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MAX_WORDS; k++) r_words[k] <= '0;
            r_key        <= '0;
            r_key_len    <= 2'd0;
            r_i          <= '0;
            r_mod        <= 3'd0;
            r_rcon       <= 8'h00;
            r_nr         <= 4'd0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_key        <= key;
                r_key_len    <= key_len;
                r_nr         <= w_nr_req;
                r_keys_valid <= 1'b0;
            end

            if (r_state == S_LOAD) begin
                for (int k = 0; k < MAX_NK; k++) begin
                    if (k < int'(w_nk)) r_words[k] <= r_key[k*32 +: 32];
                end
                r_i    <= WIDX_W'(w_nk);
                r_mod  <= 3'd0;
                r_rcon <= 8'h01;
            end

            if (r_state == S_EXPAND) begin
                r_words[r_i] <= w_back ^ w_temp;
                if (w_last_word) begin
                    r_done       <= 1'b1;
                    r_keys_valid <= 1'b1;
                end else begin
                    r_i   <= r_i + WIDX_W'(1);
                    r_mod <= (r_mod == w_nk_m1) ? 3'd0 : r_mod + 3'd1;
                end
                // rcon advances after each use (xtime, 0x80 -> 0x1B)
                if (r_mod == 3'd0) begin
                    r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                end
            end
        end
    end

    assign done       = r_done;
    assign keys_valid = r_keys_valid;
    assign nr         = r_nr;

    // ------------------------------------------------------------------
    // Round-key read port; indices past the active Nr read as zero so
    // stale words from a longer earlier mode never leak out.
    // ------------------------------------------------------------------
    assign w_base = WIDX_W'({rk_index, 2'b00});

    always_comb begin
        rk_data = '0;
        if (rk_index <= r_nr) begin
            rk_data = {r_words[w_base],
                       r_words[w_base + WIDX_W'(1)],
                       r_words[w_base + WIDX_W'(2)],
                       r_words[w_base + WIDX_W'(3)]};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_schedule_seq
// Purpose  : Self-checking bench for aes_key_schedule_seq. Known-answer
//            vectors plus random keys checked against a behavioural key
//            expansion model; covers reset, ignored requests, async reset
//            mid-run and back-to-back restarts.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_aes_key_schedule_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   key_len;
    logic [0:255] key;
    logic         ready, busy, done, keys_valid;
    logic [3:0]   nr;
    logic [3:0]   rk_index;
    logic [0:127] rk_data;

    int total = 0;
    int bad   = 0;

    logic [7:0]  sb [256];
    logic [31:0] mw [60];

    localparam logic [0:255] C_K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:255] C_K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [0:255] C_K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_key_schedule_seq #(.MAX_NK(8), .MAX_WORDS(60), .RK_IDX_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_len    (key_len),
        .key        (key),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .nr         (nr),
        .rk_index   (rk_index),
        .rk_data    (rk_data)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        logic [15:0] d;
        d = {v, v} << s;
        return d[15:8];
    endfunction

    // S-box table via the generator-3 walk (independent of field inversion)
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_of(input int j);
        logic [7:0] rc;
        rc = 8'h01;
        for (int n = 1; n < j; n++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        return rc;
    endfunction

    task automatic model_expand(input int kl, input logic [0:255] k);
        int nk, words;
        logic [31:0] t;
        nk    = 4 + 2 * kl;
        words = 4 * (nk + 7);
        for (int i = 0; i < 60; i++) mw[i] = 32'h0;
        for (int i = 0; i < nk; i++) mw[i] = k[i*32 +: 32];
        for (int i = nk; i < words; i++) begin
            t = mw[i-1];
            if (i % nk == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
            else if (nk == 8 && i % 8 == 4)
                t = subw(t);
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    function automatic logic [0:127] model_rk(input int r, input int nr_m);
        if (r > nr_m) return 128'h0;
        return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] kl, input logic [0:255] k);
        start   = 1'b1;
        key_len = kl;
        key     = k;
        tick();
        start   = 1'b0;
    endtask

    // Edges after acceptance until done is seen; -1 if the budget runs out
    task automatic wait_done(output int n);
        n = -1;
        for (int e = 1; e <= 200; e++) begin
            tick();
            if (done) begin
                n = e;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; key_len = 2'd0; key = '0; rk_index = 4'd0;
        tick(); tick();
        reset = 1'b0;
        tick();
        total++;
        if ({ready, busy, done, keys_valid} !== 4'b1000) begin
            bad++; $display("FAIL reset_flags got=%b exp=1000", {ready, busy, done, keys_valid});
        end
        total++;
        if (nr !== 4'd0 || rk_data !== 128'h0) begin
            bad++; $display("FAIL reset_data nr=%0d rk=%h exp nr=0 rk=0", nr, rk_data);
        end
        // illegal mode in IDLE is dropped
        launch(2'd3, C_K128);
        tick();
        total++;
        if ({ready, busy, keys_valid} !== 3'b100) begin
            bad++; $display("FAIL illegal_idle got=%b exp=100", {ready, busy, keys_valid});
        end
    endtask

    task automatic test_aes128();
        int n;
        model_expand(0, C_K128);
        launch(2'd0, C_K128);
        total++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            bad++; $display("FAIL a128_busy busy=%b ready=%b exp 1/0", busy, ready);
        end
        wait_done(n);
        total++;
        if (n !== 41) begin bad++; $display("FAIL a128_latency got=%0d exp=41", n); end
        total++;
        if (nr !== 4'd10 || keys_valid !== 1'b1) begin
            bad++; $display("FAIL a128_status nr=%0d kv=%b exp 10/1", nr, keys_valid);
        end
        rk_index = 4'd10; #1;
        total++;
        if (rk_data !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            bad++; $display("FAIL a128_rk10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", rk_data);
        end
        rk_index = 4'd1; #1;
        total++;
        if (rk_data !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            bad++; $display("FAIL a128_rk1 got=%h exp=a0fafe1788542cb123a339392a6c7605", rk_data);
        end
        for (int r = 0; r < 16; r++) begin
            rk_index = 4'(r); #1;
            total++;
            if (rk_data !== model_rk(r, 10)) begin
                bad++; $display("FAIL a128_model r=%0d got=%h exp=%h", r, rk_data, model_rk(r, 10));
            end
        end
        tick();
        total++;
        if (done !== 1'b0 || keys_valid !== 1'b1 || ready !== 1'b1) begin
            bad++; $display("FAIL a128_pulse done=%b kv=%b ready=%b exp 0/1/1", done, keys_valid, ready);
        end
    endtask

    task automatic test_aes192();
        int n;
        model_expand(1, C_K192);
        launch(2'd1, C_K192);
        wait_done(n);
        total++;
        if (n !== 47) begin bad++; $display("FAIL a192_latency got=%0d exp=47", n); end
        total++;
        if (nr !== 4'd12) begin bad++; $display("FAIL a192_nr got=%0d exp=12", nr); end
        rk_index = 4'd12; #1;
        total++;
        if (rk_data !== 128'he98ba06f448c773c8ecc720401002202) begin
            bad++; $display("FAIL a192_rk12 got=%h exp=e98ba06f448c773c8ecc720401002202", rk_data);
        end
        rk_index = 4'd13; #1;
        total++;
        if (rk_data !== 128'h0) begin bad++; $display("FAIL a192_rk13 got=%h exp=0", rk_data); end
        for (int r = 0; r < 16; r++) begin
            rk_index = 4'(r); #1;
            total++;
            if (rk_data !== model_rk(r, 12)) begin
                bad++; $display("FAIL a192_model r=%0d got=%h exp=%h", r, rk_data, model_rk(r, 12));
            end
        end
    endtask

    task automatic test_aes256();
        int n;
        model_expand(2, C_K256);
        launch(2'd2, C_K256);
        wait_done(n);
        total++;
        if (n !== 53) begin bad++; $display("FAIL a256_latency got=%0d exp=53", n); end
        rk_index = 4'd14; #1;
        total++;
        if (rk_data !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            bad++; $display("FAIL a256_rk14 got=%h exp=fe4890d1e6188d0b046df344706c631e", rk_data);
        end
        for (int r = 0; r < 16; r++) begin
            rk_index = 4'(r); #1;
            total++;
            if (rk_data !== model_rk(r, 14)) begin
                bad++; $display("FAIL a256_model r=%0d got=%h exp=%h", r, rk_data, model_rk(r, 14));
            end
        end
    endtask

    task automatic test_random();
        int n, kl, nr_m;
        logic [0:255] k;
        for (int it = 0; it < 6; it++) begin
            kl = int'($urandom_range(0, 2));
            for (int w = 0; w < 8; w++) k[w*32 +: 32] = $urandom;
            nr_m = 10 + 2 * kl;
            model_expand(kl, k);
            launch(2'(kl), k);
            wait_done(n);
            total++;
            if (n !== 1 + 4 * (nr_m + 1) - (4 + 2 * kl)) begin
                bad++; $display("FAIL rand_latency it=%0d got=%0d", it, n);
            end
            total++;
            if (nr !== 4'(nr_m)) begin bad++; $display("FAIL rand_nr got=%0d exp=%0d", nr, nr_m); end
            for (int r = 0; r < 16; r++) begin
                rk_index = 4'(r); #1;
                total++;
                if (rk_data !== model_rk(r, nr_m)) begin
                    bad++; $display("FAIL rand_rk it=%0d r=%0d got=%h exp=%h", it, r, rk_data, model_rk(r, nr_m));
                end
            end
        end
    endtask

    task automatic test_reset_mid_expand();
        int n;
        launch(2'd0, C_K128);
        repeat (20) tick();
        #1 reset = 1'b1;
        rk_index = 4'd0;
        #1;
        total++;
        if ({ready, busy, done, keys_valid} !== 4'b1000 || nr !== 4'd0 || rk_data !== 128'h0) begin
            bad++; $display("FAIL async_reset flags=%b nr=%0d rk=%h exp 1000/0/0",
                            {ready, busy, done, keys_valid}, nr, rk_data);
        end
        #1 reset = 1'b0;
        tick();
        model_expand(0, C_K128);
        launch(2'd0, C_K128);
        wait_done(n);
        total++;
        if (n !== 41) begin bad++; $display("FAIL rerun_latency got=%0d exp=41", n); end
        rk_index = 4'd10; #1;
        total++;
        if (rk_data !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            bad++; $display("FAIL rerun_rk10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", rk_data);
        end
    endtask

    task automatic test_ignored_starts();
        int n;
        model_expand(0, C_K128);
        launch(2'd0, C_K128);
        n = -1;
        for (int e = 1; e <= 200; e++) begin
            if (e == 10) begin
                start = 1'b1; key_len = 2'd2; key = C_K256;
            end else begin
                start = 1'b0; key = '1;
            end
            tick();
            if (done) begin n = e; break; end
        end
        start = 1'b0;
        total++;
        if (n !== 41) begin bad++; $display("FAIL busy_start_latency got=%0d exp=41", n); end
        rk_index = 4'd10; #1;
        total++;
        if (rk_data !== model_rk(10, 10) || nr !== 4'd10) begin
            bad++; $display("FAIL busy_start_rk10 got=%h nr=%0d exp=%h nr=10", rk_data, nr, model_rk(10, 10));
        end
        launch(2'd3, C_K256);
        tick();
        total++;
        if ({ready, busy, done, keys_valid} !== 4'b1001) begin
            bad++; $display("FAIL illegal_done got=%b exp=1001", {ready, busy, done, keys_valid});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        launch(2'd0, C_K128);
        wait_done(n);
        total++;
        if (n !== 41) begin bad++; $display("FAIL b2b_first got=%0d exp=41", n); end
        launch(2'd2, C_K256);
        total++;
        if (keys_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_restart kv=%b done=%b busy=%b exp 0/0/1", keys_valid, done, busy);
        end
        wait_done(n);
        total++;
        if (n !== 53) begin bad++; $display("FAIL b2b_latency got=%0d exp=53", n); end
        model_expand(2, C_K256);
        for (int r = 0; r < 16; r++) begin
            rk_index = 4'(r); #1;
            total++;
            if (rk_data !== model_rk(r, 14)) begin
                bad++; $display("FAIL b2b_rk r=%0d got=%h exp=%h", r, rk_data, model_rk(r, 14));
            end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_random();
        test_reset_mid_expand();
        test_ignored_starts();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
